mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified instruction/data memory between the multicycle core's memory interface (port 0) and a secondary bus master such as the UART program loader or debug DMA (port 1). It does per-cycle round-robin arbitration with an optional lock for bursts, a starvation limit on locks, and return of synchronous-read data with a fixed one-cycle latency. It sits between the core datapath address/write-data mux and the memory macro. The core's control FSM holds its request stable until it is granted.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK0, ARB_LOCK1} arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0   = 1'b0;
  localparam port_id_t PORT1   = 1'b1;
  localparam int       BURST_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational round-robin / lock grant decision
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  arb_state_t  state,
  input  port_id_t    last,
  input  logic        req0,
  input  logic        req1,
  output logic [1:0]  gnt
);

  always_comb begin
    gnt = 2'b00;
    case (state)
      ARB_LOCK0: gnt[0] = req0;
      ARB_LOCK1: gnt[1] = req1;
      default: begin
        // On a conflict the port that was not served last wins.
        if (req0 && req1) begin
          if (last == PORT1) gnt[0] = 1'b1;
          else               gnt[1] = 1'b1;
        end else begin
          gnt[0] = req0;
          gnt[1] = req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one synchronous-read memory between the core (port 0) and a bus master (port 1)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wd,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam logic [BURST_W-1:0] MAX_CNT  = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] ONE_CNT  = BURST_W'(1);
  localparam logic               SOLO_MAX = (MAX_CNT == ONE_CNT);

  arb_state_t         state;
  port_id_t           last;
  logic [BURST_W-1:0] burst_cnt;
  logic               rvalid0_q;
  logic               rvalid1_q;
  logic [DW-1:0]      rdata_q;
  logic [1:0]         pick;

  logic               own_is1;
  logic               own_gnt;
  logic               own_lock;
  logic               other_req;
  logic [BURST_W-1:0] cnt_inc;
  logic [BURST_W-1:0] cnt_nxt;

  mem_arb_pick u_pick (
    .state (state),
    .last  (last),
    .req0  (m0_req),
    .req1  (m1_req),
    .gnt   (pick)
  );

  assign m0_gnt  = pick[0] & ~rst;
  assign m1_gnt  = pick[1] & ~rst;

  assign mem_en  = m0_gnt | m1_gnt;
  assign mem_we  = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign mem_adr = m1_gnt ? m1_adr : m0_adr;
  assign mem_wd  = m1_gnt ? m1_wd  : m0_wd;

  // The memory itself is the read register; rdata_q only holds the last word between reads.
  assign m0_rvalid = rvalid0_q & ~rst;
  assign m1_rvalid = rvalid1_q & ~rst;
  assign rdata     = rst ? '0 : ((rvalid0_q | rvalid1_q) ? mem_rd : rdata_q);

  always_comb begin
    own_is1   = (state == ARB_LOCK1);
    own_gnt   = own_is1 ? m1_gnt  : m0_gnt;
    own_lock  = own_is1 ? m1_lock : m0_lock;
    other_req = own_is1 ? m0_req  : m1_req;
    cnt_inc   = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + ONE_CNT;
    cnt_nxt   = own_gnt ? cnt_inc : burst_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      last      <= PORT1;
      burst_cnt <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid0_q <= m0_gnt & ~m0_we;
      rvalid1_q <= m1_gnt & ~m1_we;
      if (rvalid0_q | rvalid1_q) rdata_q <= mem_rd;

      if (m0_gnt)      last <= PORT0;
      else if (m1_gnt) last <= PORT1;

      case (state)
        ARB_IDLE: begin
          burst_cnt <= '0;
          // With a one-grant limit and a waiting contender the lock is released at once.
          if (m0_gnt && m0_lock && !(SOLO_MAX && m1_req)) begin
            state     <= ARB_LOCK0;
            burst_cnt <= ONE_CNT;
          end else if (m1_gnt && m1_lock && !(SOLO_MAX && m0_req)) begin
            state     <= ARB_LOCK1;
            burst_cnt <= ONE_CNT;
          end
        end
        ARB_LOCK0, ARB_LOCK1: begin
          burst_cnt <= cnt_nxt;
          if ((own_gnt && !own_lock) || (cnt_nxt == MAX_CNT && other_req)) begin
            state     <= ARB_IDLE;
            burst_cnt <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with directed, hand-computed vectors
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic        lock;
    logic [31:0] adr;
    logic [31:0] wd;
    int          pre;
  } txn_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
  } gexp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_adr, m0_wd, m1_adr, m1_wd;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_adr, mem_wd;
  logic [31:0] mem_rd = 32'h0;

  txn_t  q0[$];
  txn_t  q1[$];
  gexp_t eg[$];
  rexp_t er[$];
  int    errors = 0;
  int    checks = 0;
  logic  g0_s = 1'b0;
  logic  g1_s = 1'b0;

  logic [31:0] wmem  [0:255];
  logic        wvalid[0:255];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_adr(m0_adr), .m0_wd(m0_wd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_adr(m1_adr), .m1_wd(m1_wd),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : (32'hA000_0000 | {24'h0, a});
  endfunction

  // Synchronous-read memory; unwritten words read back their address-derived seed.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wmem[mem_adr[7:0]]   <= mem_wd;
        wvalid[mem_adr[7:0]] <= 1'b1;
      end else begin
        mem_rd <= (wvalid[mem_adr[7:0]] === 1'b1) ? wmem[mem_adr[7:0]] : init_val(mem_adr[7:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t tx(input logic we, input logic lock, input logic [31:0] adr,
                              input logic [31:0] wd, input int pre);
    txn_t t;
    t.we = we; t.lock = lock; t.adr = adr; t.wd = wd; t.pre = pre;
    return t;
  endfunction

  task automatic exp_g(input logic port, input logic we, input logic [31:0] adr, input logic [31:0] wd);
    gexp_t e;
    e.port = port; e.we = we; e.adr = adr; e.wd = wd;
    eg.push_back(e);
  endtask

  task automatic exp_r(input logic port, input logic [31:0] data);
    rexp_t e;
    e.port = port; e.data = data;
    er.push_back(e);
  endtask

  always @(negedge clk) begin
    g0_s = m0_gnt;
    g1_s = m1_gnt;
  end

  initial begin : drv0
    txn_t c;
    bit   busy;
    int   idle;
    c = tx(1'b0, 1'b0, 32'h0, 32'h0, 0);
    busy = 0; idle = 0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_adr = 0; m0_wd = 0;
    forever begin
      @(posedge clk); #1;
      if (m0_req && g0_s) busy = 0;
      if (!busy && q0.size() > 0) begin c = q0.pop_front(); busy = 1; idle = c.pre; end
      if (busy && idle > 0) begin idle--; m0_req = 0; end
      else m0_req = busy;
      m0_we = c.we; m0_lock = c.lock; m0_adr = c.adr; m0_wd = c.wd;
    end
  end

  initial begin : drv1
    txn_t c;
    bit   busy;
    int   idle;
    c = tx(1'b0, 1'b0, 32'h0, 32'h0, 0);
    busy = 0; idle = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_adr = 0; m1_wd = 0;
    forever begin
      @(posedge clk); #1;
      if (m1_req && g1_s) busy = 0;
      if (!busy && q1.size() > 0) begin c = q1.pop_front(); busy = 1; idle = c.pre; end
      if (busy && idle > 0) begin idle--; m1_req = 0; end
      else m1_req = busy;
      m1_we = c.we; m1_lock = c.lock; m1_adr = c.adr; m1_wd = c.wd;
    end
  end

  initial begin : monitor
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m0_gnt || m1_gnt) begin
          check("gnt_onehot", {31'h0, m0_gnt & m1_gnt}, 32'h0);
          if (eg.size() == 0) begin
            check("unexpected_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
          end else begin
            g = eg.pop_front();
            check("gnt_port", {31'h0, m1_gnt}, {31'h0, g.port});
            check("mem_adr", mem_adr, g.adr);
            check("mem_we_en", {30'h0, mem_en, mem_we}, {30'h0, 1'b1, g.we});
            if (g.we) check("mem_wd", mem_wd, g.wd);
          end
        end else begin
          check("idle_mem_en_we", {30'h0, mem_en, mem_we}, 32'h0);
        end
        if (m0_rvalid || m1_rvalid) begin
          if (er.size() == 0) begin
            check("unexpected_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
          end else begin
            r = er.pop_front();
            check("rvalid_port", {30'h0, m1_rvalid, m0_rvalid}, r.port ? 32'h2 : 32'h1);
            check("rdata", rdata, r.data);
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m0_req || m1_req || eg.size() > 0 || er.size() > 0)
           && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_%s: pending grants %0d reads %0d after %0d cycles, required 0",
               name, eg.size(), er.size(), n);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    for (int i = 0; i < 256; i++) wvalid[i] = 1'b0;
    rst = 1'b1;

    // Reset state with a request pending, then a lone m0 read of 0x10.
    q0.push_back(tx(1'b0, 1'b0, 32'h10, 32'h0, 0));
    exp_g(1'b0, 1'b0, 32'h10, 32'h0);
    exp_r(1'b0, 32'hDEAD_BEEF);
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
      check("rst_mem_en_we", {30'h0, mem_en, mem_we}, 32'h0);
      check("rst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
    end
    @(posedge clk); #1 rst = 1'b0;
    drain("single_read");

    // Both ports from the first cycle after reset: m0, m1, m0, m1.
    @(posedge clk); #1 rst = 1'b1;
    q0.push_back(tx(1'b0, 1'b0, 32'h00, 32'h0, 0));
    q0.push_back(tx(1'b0, 1'b0, 32'h08, 32'h0, 0));
    q1.push_back(tx(1'b0, 1'b0, 32'h04, 32'h0, 0));
    q1.push_back(tx(1'b0, 1'b0, 32'h0C, 32'h0, 0));
    exp_g(1'b0, 1'b0, 32'h00, 32'h0); exp_r(1'b0, 32'hA000_0000);
    exp_g(1'b1, 1'b0, 32'h04, 32'h0); exp_r(1'b1, 32'hA000_0004);
    exp_g(1'b0, 1'b0, 32'h08, 32'h0); exp_r(1'b0, 32'hA000_0008);
    exp_g(1'b1, 1'b0, 32'h0C, 32'h0); exp_r(1'b1, 32'hA000_000C);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drain("alternate");

    // m1 locked burst of 12 writes against a waiting m0: 8 grants, forced release, m0, then m1 again.
    @(posedge clk);
    for (int i = 0; i < 12; i++)
      q1.push_back(tx(1'b1, (i < 11), 32'h40 + i, 32'h100 + i, 0));
    q0.push_back(tx(1'b0, 1'b0, 32'h50, 32'h0, 1));
    q0.push_back(tx(1'b0, 1'b0, 32'h51, 32'h0, 0));
    q0.push_back(tx(1'b0, 1'b0, 32'h52, 32'h0, 0));
    for (int i = 0; i < 8; i++) exp_g(1'b1, 1'b1, 32'h40 + i, 32'h100 + i);
    exp_g(1'b0, 1'b0, 32'h50, 32'h0); exp_r(1'b0, 32'hA000_0050);
    for (int i = 8; i < 12; i++) exp_g(1'b1, 1'b1, 32'h40 + i, 32'h100 + i);
    exp_g(1'b0, 1'b0, 32'h51, 32'h0); exp_r(1'b0, 32'hA000_0051);
    exp_g(1'b0, 1'b0, 32'h52, 32'h0); exp_r(1'b0, 32'hA000_0052);
    drain("burst_limit");

    // Locked m0 owner pauses two cycles; m1 must wait until m0 drops lock.
    @(posedge clk);
    q0.push_back(tx(1'b0, 1'b1, 32'h60, 32'h0, 0));
    q0.push_back(tx(1'b0, 1'b1, 32'h61, 32'h0, 2));
    q0.push_back(tx(1'b0, 1'b0, 32'h62, 32'h0, 0));
    q1.push_back(tx(1'b0, 1'b0, 32'h70, 32'h0, 1));
    exp_g(1'b0, 1'b0, 32'h60, 32'h0); exp_r(1'b0, 32'hA000_0060);
    exp_g(1'b0, 1'b0, 32'h61, 32'h0); exp_r(1'b0, 32'hA000_0061);
    exp_g(1'b0, 1'b0, 32'h62, 32'h0); exp_r(1'b0, 32'hA000_0062);
    exp_g(1'b1, 1'b0, 32'h70, 32'h0); exp_r(1'b1, 32'hA000_0070);
    drain("idle_owner");

    // Reset right after a locked m1 read grant.
    @(posedge clk);
    q1.push_back(tx(1'b0, 1'b1, 32'h30, 32'h0, 0));
    exp_g(1'b1, 1'b0, 32'h30, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m1_gnt && n < 50);
    checks++;
    if (!m1_gnt) begin
      errors++;
      $display("FAIL lock_gnt_wait: m1_gnt got 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_mem_en", {31'h0, mem_en}, 32'h0);
    q0.push_back(tx(1'b0, 1'b0, 32'h34, 32'h0, 0));
    q1.push_back(tx(1'b0, 1'b0, 32'h38, 32'h0, 0));
    exp_g(1'b0, 1'b0, 32'h34, 32'h0); exp_r(1'b0, 32'hA000_0034);
    exp_g(1'b1, 1'b0, 32'h38, 32'h0); exp_r(1'b1, 32'hA000_0038);
    @(posedge clk); #1 rst = 1'b0;
    drain("reset_midburst");

    // m0 writes 0x1234 to 0x20, m1 reads it back; the write yields no rvalid.
    @(posedge clk);
    q0.push_back(tx(1'b1, 1'b0, 32'h20, 32'h1234, 0));
    q1.push_back(tx(1'b0, 1'b0, 32'h20, 32'h0, 1));
    exp_g(1'b0, 1'b1, 32'h20, 32'h1234);
    exp_g(1'b1, 1'b0, 32'h20, 32'h0); exp_r(1'b1, 32'h0000_1234);
    drain("write_read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
